// File: rtl/freq_synth.sv
// Phase-accumulator square-wave synthesiser; the increment comes from an on-chip restoring divider.
// Optional FREQ_SYNTH_READBACK_EN registers the applied frequency on freq_act.
`ifndef CLK_FREQ
`define CLK_FREQ 12000000
`endif

module freq_synth #(
   parameter int unsigned ACC_W = 32
) (
   input  logic        sys_clock,
   input  logic        sys_reset_n,
   input  logic [23:0] freq_in,
   input  logic        load,
   output logic        busy,
   output logic        err,
   output logic [23:0] freq_act,
   output logic        synth_out
);

   localparam int unsigned CLK_HZ = `CLK_FREQ;
   localparam int unsigned R_W    = $clog2(CLK_HZ) + 1;
   localparam int unsigned F10_W  = 28;
   localparam int unsigned CNT_W  = $clog2(ACC_W);
   localparam logic [F10_W-1:0] NYQ     = F10_W'(CLK_HZ / 2);
   localparam logic [R_W-1:0]   DIVISOR = R_W'(CLK_HZ);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_WAIT} state_t;

   state_t             state, state_nxt;
   logic [ACC_W-1:0]   acc, inc, inc_nxt;
   logic [ACC_W-1:0]   pending, pending_nxt;
   logic [R_W-1:0]     r, r_nxt, r_sh_c;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               err_nxt;
   logic [F10_W-1:0]   f10_c;
   logic [ACC_W:0]     sum_c;
   logic               wrap_c;
   logic               accept_c;
   logic               apply_c;

   assign f10_c  = F10_W'(freq_in) * F10_W'(10);
   assign sum_c  = {1'b0, acc} + {1'b0, inc};
   assign wrap_c = sum_c[ACC_W];
   assign r_sh_c = {r[R_W-2:0], 1'b0};

   // Next-state: load acceptance, one quotient bit per DIV cycle, apply at a wrap
   always_comb begin
      state_nxt   = state;
      r_nxt       = r;
      pending_nxt = pending;
      cnt_nxt     = cnt;
      inc_nxt     = inc;
      err_nxt     = err;
      accept_c    = 1'b0;
      apply_c     = 1'b0;
      case (state)
         S_IDLE: begin
            if (load) begin
               if (f10_c >= NYQ) begin
                  err_nxt = 1'b1;
               end else begin
                  err_nxt     = 1'b0;
                  accept_c    = 1'b1;
                  r_nxt       = R_W'(f10_c);
                  pending_nxt = '0;
                  cnt_nxt     = '0;
                  state_nxt   = S_DIV;
               end
            end
         end
         S_DIV: begin
            if (r_sh_c >= DIVISOR) begin
               r_nxt       = r_sh_c - DIVISOR;
               pending_nxt = {pending[ACC_W-2:0], 1'b1};
            end else begin
               r_nxt       = r_sh_c;
               pending_nxt = {pending[ACC_W-2:0], 1'b0};
            end
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(ACC_W - 1)) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if ((inc == '0) || wrap_c) begin
               inc_nxt   = pending;
               apply_c   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clock or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state     <= S_IDLE;
         acc       <= '0;
         inc       <= '0;
         pending   <= '0;
         r         <= '0;
         cnt       <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
         synth_out <= 1'b0;
      end else begin
         state     <= state_nxt;
         acc       <= sum_c[ACC_W-1:0];
         inc       <= inc_nxt;
         pending   <= pending_nxt;
         r         <= r_nxt;
         cnt       <= cnt_nxt;
         err       <= err_nxt;
         busy      <= (state_nxt != S_IDLE);
         synth_out <= acc[ACC_W-1];
      end
   end

`ifdef FREQ_SYNTH_READBACK_EN
   logic [23:0] freq_smp;

   // Sampled request follows the increment through to the apply cycle
   always_ff @(posedge sys_clock or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         freq_smp <= '0;
         freq_act <= '0;
      end else begin
         if (accept_c) freq_smp <= freq_in;
         if (apply_c)  freq_act <= freq_smp;
      end
   end
`else
   assign freq_act = 24'd0;
`endif

endmodule

// File: tb/tb_freq_synth.sv
// Directed bench for freq_synth at CLK_FREQ = 12 MHz, ACC_W = 32.
`ifndef CLK_FREQ
`define CLK_FREQ 12000000
`endif

module tb_freq_synth;
   localparam int unsigned ACC_W = 32;
`ifdef FREQ_SYNTH_READBACK_EN
   localparam logic READBACK = 1'b1;
`else
   localparam logic READBACK = 1'b0;
`endif

   typedef struct {
      logic [23:0] f;
      logic        exp_err;
      logic        exp_acc;
      logic [31:0] exp_inc;
   } vec_t;

   logic        sys_clock = 1'b0;
   logic        sys_reset_n;
   logic [23:0] freq_in;
   logic        load;
   logic        busy;
   logic        err;
   logic [23:0] freq_act;
   logic        synth_out;

   int n_chk  = 0;
   int n_pass = 0;

   int   min_run, run_len;
   bit   seen_chg;
   logic prev_out;

   freq_synth #(.ACC_W(ACC_W)) dut (
      .sys_clock   (sys_clock),
      .sys_reset_n (sys_reset_n),
      .freq_in     (freq_in),
      .load        (load),
      .busy        (busy),
      .err         (err),
      .freq_act    (freq_act),
      .synth_out   (synth_out)
   );

   always #5 sys_clock = ~sys_clock;

   function automatic logic [23:0] exp_act(input logic [23:0] v);
      return v & {24{READBACK}};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic do_reset();
      sys_reset_n = 1'b0;
      repeat (2) @(negedge sys_clock);
      sys_reset_n = 1'b1;
      @(negedge sys_clock);
   endtask

   // Strobe load for one posedge; returns in the middle of cycle N+1
   task automatic do_load(input logic [23:0] f);
      @(negedge sys_clock);
      freq_in = f;
      load    = 1'b1;
      @(negedge sys_clock);
      load    = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int k = 0;
      while (busy === 1'b1 && k < limit) begin
         @(negedge sys_clock);
         k++;
      end
      if (busy !== 1'b0) begin
         n_chk++;
         $display("FAIL wait_idle: busy still %b after %0d cycles", busy, limit);
      end
   endtask

   task automatic measure(input int n, output int rises, output int highs,
                          output int min_gap, output int max_gap);
      int   last;
      logic p;
      rises = 0; highs = 0; min_gap = 1 << 30; max_gap = 0; last = -1;
      p = synth_out;
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clock);
         if (synth_out === 1'b1) highs++;
         if (p === 1'b0 && synth_out === 1'b1) begin
            rises++;
            if (last >= 0) begin
               if (i - last < min_gap) min_gap = i - last;
               if (i - last > max_gap) max_gap = i - last;
            end
            last = i;
         end
         p = synth_out;
      end
   endtask

   // One cycle step that also tracks the shortest complete high/low run
   task automatic tick_mon();
      @(negedge sys_clock);
      if (synth_out !== prev_out) begin
         if (seen_chg && run_len < min_run) min_run = run_len;
         seen_chg = 1'b1;
         run_len  = 1;
      end else begin
         run_len++;
      end
      prev_out = synth_out;
   endtask

   initial begin
      vec_t vecs[9];
      int   cnt, rises, highs, gmin, gmax;
      logic [23:0] act_exp;

      vecs[0] = '{24'd600000,   1'b1, 1'b0, 32'd0};
      vecs[1] = '{24'd16777215, 1'b1, 1'b0, 32'd0};
      vecs[2] = '{24'd599999,   1'b0, 1'b1, 32'd2147480068};
      vecs[3] = '{24'd300000,   1'b0, 1'b1, 32'd1073741824};
      vecs[4] = '{24'd100000,   1'b0, 1'b1, 32'd357913941};
      vecs[5] = '{24'd1000,     1'b0, 1'b1, 32'd3579139};
      vecs[6] = '{24'd150000,   1'b0, 1'b1, 32'd536870912};
      vecs[7] = '{24'd0,        1'b0, 1'b1, 32'd0};
      vecs[8] = '{24'd1,        1'b0, 1'b1, 32'd3579};

      freq_in = '0;
      load    = 1'b0;
      do_reset();

      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_synth", 64'(synth_out), 64'd0);
      chk("rst_freq_act", 64'(freq_act), 64'd0);
      chk("rst_inc", 64'(dut.inc), 64'd0);

      // Exact divide: 33 busy cycles with immediate apply, period 4
      do_load(24'd300000);
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge sys_clock);
      end
      chk("exact_busy_len", 64'(cnt), 64'd33);
      chk("exact_inc", 64'(dut.inc), 64'd1073741824);
      chk("exact_freq_act", 64'(freq_act), 64'(exp_act(24'd300000)));
      measure(40, rises, highs, gmin, gmax);
      chk("exact_highs", 64'(highs), 64'd20);
      chk("exact_min_gap", 64'(gmin), 64'd4);
      chk("exact_max_gap", 64'(gmax), 64'd4);

      // Glitch-free retune 300000 -> 150000
      prev_out = synth_out; seen_chg = 1'b0; run_len = 1; min_run = 1000;
      freq_in = 24'd150000;
      load    = 1'b1;
      tick_mon();
      load    = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 200) begin
         tick_mon();
         cnt++;
      end
      chk("retune_done", 64'(busy), 64'd0);
      repeat (40) tick_mon();
      chk("retune_min_run_ge2", 64'(min_run >= 2), 64'd1);
      chk("retune_inc", 64'(dut.inc), 64'd536870912);
      measure(80, rises, highs, gmin, gmax);
      chk("retune_highs", 64'(highs), 64'd40);
      chk("retune_min_gap", 64'(gmin), 64'd8);
      chk("retune_max_gap", 64'(gmax), 64'd8);

      // Async reset in DIV cycle 10
      do_load(24'd300000);
      repeat (9) @(negedge sys_clock);
      chk("div10_busy", 64'(busy), 64'd1);
      sys_reset_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_synth", 64'(synth_out), 64'd0);
      chk("arst_inc", 64'(dut.inc), 64'd0);
      chk("arst_acc", 64'(dut.acc), 64'd0);
      chk("arst_freq_act", 64'(freq_act), 64'd0);
      @(negedge sys_clock);
      sys_reset_n = 1'b1;
      repeat (40) @(negedge sys_clock);
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_inc", 64'(dut.inc), 64'd0);
      chk("post_rst_synth", 64'(synth_out), 64'd0);

      // Busy lockout: second load during DIV is ignored
      do_load(24'd300000);
      repeat (3) @(negedge sys_clock);
      do_load(24'd100000);
      wait_idle(200);
      chk("lockout_inc", 64'(dut.inc), 64'd1073741824);
      chk("lockout_freq_act", 64'(freq_act), 64'(exp_act(24'd300000)));

      // Stop: freq 0 parks the output low
      do_load(24'd0);
      wait_idle(200);
      chk("stop_inc", 64'(dut.inc), 64'd0);
      repeat (2) @(negedge sys_clock);
      measure(50, rises, highs, gmin, gmax);
      chk("stop_highs", 64'(highs), 64'd0);

      // Fractional rate: about 1000 rising edges in 12000 cycles
      do_load(24'd100000);
      wait_idle(200);
      chk("frac_inc", 64'(dut.inc), 64'd357913941);
      measure(12000, rises, highs, gmin, gmax);
      chk("frac_rises_in_range", 64'(rises >= 999 && rises <= 1001), 64'd1);

      // Vector table from a fresh reset
      do_reset();
      act_exp = '0;
      for (int i = 0; i < 9; i++) begin
         do_load(vecs[i].f);
         chk($sformatf("vec%0d_err_n1", i), 64'(err), 64'(vecs[i].exp_err));
         chk($sformatf("vec%0d_busy_n1", i), 64'(busy), 64'(vecs[i].exp_acc));
         wait_idle(3000);
         if (vecs[i].exp_acc) act_exp = vecs[i].f;
         chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
         chk($sformatf("vec%0d_inc", i), 64'(dut.inc), 64'(vecs[i].exp_inc));
         chk($sformatf("vec%0d_freq_act", i), 64'(freq_act), 64'(exp_act(act_exp)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/freq_synth.md
# freq_synth

Programmable square-wave generator, the transmit-side counterpart of the frequency counter in the instrument set. It drives a test clock into the DUT at a requested frequency in 10 Hz units, the same units the counter reports. This lets a bench close the loop: synthesise, then measure. It uses a phase accumulator clocked by `sys_clock`, with the increment computed on-chip by a sequential divider. Frequency changes take effect glitch-free at a phase wrap.

## Interface
- `ACC_W`, 32: phase accumulator and increment width. Must be at least 8.
- The `sys_clock` frequency in Hz comes from the global `` `CLK_FREQ `` define. It is not a parameter.
- `sys_clock`, in, 1: the only clock.
- `sys_reset_n`, in, 1: reset, asynchronous and active-low.
- `freq_in`, in, 24: requested frequency in 10 Hz units.
- `load`, in, 1: one-cycle strobe that samples `freq_in`.
- `busy`, out, 1: high from load acceptance until the new increment is applied.
- `err`, out, 1: the last load was rejected as over the Nyquist limit.
- `freq_act`, out, 24: the currently applied `freq_in` value (see Configuration).
- `synth_out`, out, 1: generated square wave, registered.

## Operation
- **Reset values:**
  - `acc`, `inc`, `pending` and `freq_act` are 0.
  - `busy`, `err` and `synth_out` are 0.
- **Output:** `synth_out` <= `acc[ACC_W-1]` every cycle.
- **Accumulator:** `acc` <= `acc` + `inc` modulo 2^ACC_W.
- **Computing f10:** `f10` = `freq_in`×10, computed at 28 bits. The maximum value is 167772150, so no overflow is possible.
- **Load handling:**
  - `load` is ignored while `busy`=1.
  - A `load` with `busy`=0 is accepted.
  - The request is rejected if `f10` ≥ `CLK_FREQ`/2, using integer division. On rejection, `err`<=1, `busy` stays 0, and `inc`/`freq_act` are unchanged.
  - Otherwise `err`<=0 and the FSM moves to DIV.
- **FSM states:**
  - IDLE: on an accepted, valid `load`, set r=`f10` and q=0, go to DIV, set `busy`=1.
  - DIV: exactly ACC_W cycles of restoring division.
    - Each cycle: r'=r<<1. If r' ≥ `CLK_FREQ`, then r=r'−`CLK_FREQ` and shift in 1; else r=r' and shift in 0.
    - r is `$clog2(CLK_FREQ)`+1 bits wide.
    - Result: `pending` = floor(`f10`·2^ACC_W / `CLK_FREQ`). Then go to WAIT.
  - WAIT: apply `pending` to `inc` (and `freq_in`'s sampled value to `freq_act`) in the first cycle where the current `inc`==0 or `acc`+`inc` carries out of ACC_W bits. Then go to IDLE with `busy`=0.
- **freq_in = 0:**
  - Gives `inc`=0.
  - Applied at a wrap, so `acc` is near 0 and `synth_out` parks low.
- **Sampling:** `freq_in` is sampled only at acceptance. Later changes have no effect until the next `load`.

## Timing
- `load` accepted in cycle N:
  - Rejection: `err` is visible at N+1.
  - Accepted: `busy`=1 at N+1.
  - DIV occupies N+1..N+ACC_W.
  - WAIT is entered at N+ACC_W+1.
- Apply latency:
  - If the old `inc`==0, the apply cycle is N+ACC_W+1.
  - Otherwise it is at most one output period later.
  - `busy` falls in the cycle after apply.
  - The new phase step is used from apply+1.
- `synth_out` lags `acc` MSB by 1 cycle.
- `err` persists until the next accepted `load`.
- `sys_reset_n` asserted mid-DIV or mid-WAIT:
  - Returns immediately to reset values.
  - The pending result is discarded.
- A `load` in the same cycle as an apply is ignored, because `busy` is still 1.

## Configuration
- `FREQ_SYNTH_READBACK_EN` defined: `freq_act` is registered as described, so software can read back the applied frequency.
- Undefined: `freq_act` is tied to 24'd0 and its register is removed. All other behaviour is identical.

## Test plan
All cases use `CLK_FREQ` = 12000000 and ACC_W = 32.
- Exact divide:
  - Stimulus: reset, then `load` with `freq_in`=300000.
  - Required: `busy` is high for 33 cycles (32 DIV cycles plus the immediate apply, since `inc` was 0). `inc`=1073741824. `synth_out` has a period of exactly 4 cycles with 50% duty.
- Nyquist limit:
  - `freq_in`=600000: `err`=1 at N+1, `busy` never rises, `synth_out` unchanged.
  - Then `freq_in`=599999: accepted, `err` clears.
- Fractional rate:
  - Stimulus: `freq_in`=100000, giving `inc`=357913941.
  - Required: 100000±1 rising edges over 1200000 cycles.
- Glitch-free retune:
  - Stimulus: running at 300000, `load` 150000.
  - Required: no high or low phase shorter than 2 cycles across the transition. The new period of 8 cycles starts after a wrap.
- Busy lockout and stop:
  - A `load` during DIV is ignored (`pending` reflects the first value).
  - Then `freq_in`=0: `synth_out` goes low after the next wrap and stays low.
- Async reset:
  - Stimulus: assert `sys_reset_n`=0 in DIV cycle 10.
  - Required: `busy`, `synth_out` and `inc` are 0 immediately.
  - With `FREQ_SYNTH_READBACK_EN` defined: `freq_act` is 0 after reset.
